uart_tx: RTL and testbench

- UART transmitter. It is the transmit-side counterpart of the team's uart_rx and shares the same clock, baud and frame conventions.
- Serialises bytes from the matrix-calculator result path onto the host serial line.
- Contains a small TX FIFO with a valid/ready write handshake, so upstream logic can push result characters in bursts.
- Frame format: 8N1, LSB first. An optional parity bit is available through a compile-time macro.

---
 rtl/uart_tx.sv | 194 +++++++++++++++++++
 tb/tb_uart_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter with a small TX FIFO (valid/ready write side), 8N1 LSB first.
// Define UART_TX_PARITY_EN at compile time to insert an even-parity bit (8E1).
module uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ZERO  = PTR_W'(0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  logic [7:0]        mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]  count_r, count_nxt_s;
  logic              ready_r;
  state_t            state_r;
  logic [BAUD_W-1:0] baud_cnt_r;
  logic [2:0]        bit_idx_r;
  logic [7:0]        shift_r;
  logic              tx_r, busy_r;
`ifdef UART_TX_PARITY_EN
  logic              par_r;
`endif
  logic              baud_end_s, push_s, pop_s;
  logic [7:0]        head_s;

  assign tx_ready   = ready_r;
  assign tx         = tx_r;
  assign tx_busy    = busy_r;
  assign fifo_count = count_r;

  // Handshake, pop request and next FIFO occupancy.
  always_comb begin
    baud_end_s = (baud_cnt_r == BAUD_LAST);
    push_s     = tx_valid && ready_r;
    head_s     = mem_r[rd_ptr_r];
    pop_s      = 1'b0;
    case (state_r)
      S_IDLE:  pop_s = (count_r != CNT_ZERO);
      S_STOP:  pop_s = baud_end_s && (count_r != CNT_ZERO);
      default: pop_s = 1'b0;
    endcase
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      ready_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      ready_r <= (count_nxt_s != CNT_FULL);
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= tx_data;
  end

  // Frame sequencer: every line bit is held for BAUD_DIV clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      baud_cnt_r <= BAUD_ZERO;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_r      <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: baud_cnt_r <= BAUD_ZERO;
        S_START: begin
          if (baud_end_s) begin
            state_r    <= S_DATA;
            baud_cnt_r <= BAUD_ZERO;
            bit_idx_r  <= 3'd0;
            tx_r       <= shift_r[0];
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_ONE;
          end
        end
        S_DATA: begin
          if (baud_end_s) begin
            baud_cnt_r <= BAUD_ZERO;
            if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_r <= S_PARITY;
              tx_r    <= par_r;
`else
              state_r <= S_STOP;
              tx_r    <= 1'b1;
`endif
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_end_s) begin
            state_r    <= S_STOP;
            baud_cnt_r <= BAUD_ZERO;
            tx_r       <= 1'b1;
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_ONE;
          end
        end
`endif
        S_STOP: begin
          if (baud_end_s) begin
            state_r    <= S_IDLE;
            baud_cnt_r <= BAUD_ZERO;
            busy_r     <= 1'b0;
            tx_r       <= 1'b1;
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_ONE;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          baud_cnt_r <= BAUD_ZERO;
          busy_r     <= 1'b0;
          tx_r       <= 1'b1;
        end
      endcase
      // A pop (from IDLE or at the end of STOP) overrides the above and starts a frame.
      if (pop_s) begin
        state_r    <= S_START;
        baud_cnt_r <= BAUD_ZERO;
        shift_r    <= head_s;
        tx_r       <= 1'b0;
        busy_r     <= 1'b1;
`ifdef UART_TX_PARITY_EN
        par_r      <= even_parity(head_s);
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed steps with random bytes, checked against
// a frame-level line model and a mid-bit sampling receiver.
module tb_uart_tx;

  localparam int CLK_FREQ  = 50_000_000;
  localparam int BAUD_RATE = 115200;
  localparam int DEPTH     = 4;
  localparam int BD        = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * BD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b1;
  logic [7:0] tx_data = 8'h41;
  logic       tx_ready, tx, tx_busy;
  logic [2:0] fifo_count;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         fs_q[$];

  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Expected line level for bit k of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NB == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b, output int edge_no);
    int w = 0;
    tx_valid = 1'b1;
    tx_data  = b;
    while (tx_ready !== 1'b1 && w < 2 * FRAME) begin
      step();
      w++;
    end
    check("push_timeout", 32'(w < 2 * FRAME), 32'd1);
    step();
    edge_no  = cyc;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    exp_q.push_back(b);
  endtask

  task automatic wait_idle(input int bound);
    int w = 0;
    step();
    while ((tx_busy !== 1'b0 || fifo_count !== 3'd0) && w < bound) begin
      step();
      w++;
    end
    check("idle_timeout", 32'(w < bound), 32'd1);
  endtask

  task automatic compare_rx();
    check("rx_count", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) check($sformatf("rx_byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
    end
    rx_q.delete();
    exp_q.delete();
    fs_q.delete();
  endtask

  // Receiver: detects a start bit, samples each bit mid-way, checks framing.
  initial begin
    logic          active;
    int            start, k;
    logic [NB-1:0] bits;
    active = 1'b0;
    start  = 0;
    k      = 0;
    bits   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
      end else if (!active && tx === 1'b0) begin
        active = 1'b1;
        start  = cyc;
        k      = 0;
      end
      if (active && !rst && cyc == start + k * BD + BD / 2) begin
        bits[k] = tx;
        k++;
        if (k == NB) begin
          active = 1'b0;
          check("mon_start_bit", 32'(bits[0]), 32'd0);
          check("mon_stop_bit", 32'(bits[NB-1]), 32'd1);
          if (NB == 11) check("mon_parity", 32'(bits[NB-2]), 32'(^bits[8:1]));
          rx_q.push_back(bits[8:1]);
          fs_q.push_back(start);
        end
      end
    end
  end

  initial begin
    int e0, en, w, bad, busy_cnt, off;
    int eb[5];
    logic [7:0] burst[5];
    logic [7:0] r;
    burst = '{8'h33, 8'h20, 8'h31, 8'h20, 8'h32};

    // Reset held with a pending byte on the input.
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_ready", 32'(tx_ready), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_busy", 32'(tx_busy), 32'd0);
    end
    rst = 1'b0;
    tx_valid = 1'b0;
    step();
    check("ready_after_rst", 32'(tx_ready), 32'd1);
    bad = 0;
    repeat (20) begin
      step();
      if (tx !== 1'b1 || fifo_count !== 3'd0) bad++;
    end
    check("no_frame_after_rst", 32'(bad), 32'd0);

    // Single byte: timing, bit pattern, busy length.
    push(8'h33, e0);
    check("single_pre_tx", 32'(tx), 32'd1);
    check("single_count", 32'(fifo_count), 32'd1);
    busy_cnt = 0;
    for (int i = 1; i <= FRAME + 20; i++) begin
      step();
      off = cyc - (e0 + 1);
      if (i == 1) check("single_fall", 32'(tx), 32'd0);
      if (tx_busy === 1'b1) busy_cnt++;
      if (off % BD == BD / 2 && off / BD < NB)
        check($sformatf("single_bit%0d", off / BD), 32'(tx), 32'(frame_bit(8'h33, off / BD)));
    end
    check("single_busy_len", 32'(busy_cnt), 32'(FRAME));
    compare_rx();

    // Burst of five on consecutive cycles, then hold 0x41 against a full FIFO.
    for (int k = 0; k < 5; k++) push(burst[k], eb[k]);
    for (int k = 1; k < 5; k++) check($sformatf("burst_edge%0d", k), 32'(eb[k] - eb[0]), 32'(k));
    check("burst_count_full", 32'(fifo_count), 32'd4);
    check("burst_ready_low", 32'(tx_ready), 32'd0);
    tx_valid = 1'b1;
    tx_data  = 8'h41;
    w = 0;
    bad = 0;
    while (tx_ready !== 1'b1 && w < FRAME + 50) begin
      if (fifo_count !== 3'd4) bad++;
      step();
      w++;
    end
    check("full_no_push", 32'(bad), 32'd0);
    check("full_space_edge", 32'(cyc), 32'(eb[0] + 1 + FRAME));
    step();
    tx_valid = 1'b0;
    exp_q.push_back(8'h41);
    check("full_accept_count", 32'(fifo_count), 32'd4);
    wait_idle(7 * FRAME);
    check("burst_end_edge", 32'(cyc), 32'(eb[0] + 1 + 6 * FRAME));
    check("burst_frames", 32'(fs_q.size()), 32'd6);
    for (int k = 0; k < fs_q.size(); k++)
      check($sformatf("burst_start%0d", k), 32'(fs_q[k]), 32'(eb[0] + 1 + k * FRAME));
    if (fs_q.size() == 6) check("burst_total", 32'(fs_q[5] - fs_q[0]), 32'(5 * FRAME));
    compare_rx();

    // Reset during data bit 3 of 0x55 with two bytes queued behind it.
    push(8'h55, e0);
    push(8'($urandom), en);
    push(8'($urandom), en);
    w = 0;
    while (cyc < e0 + 1 + 4 * BD + BD / 2 && w < 2 * FRAME) begin
      step();
      w++;
    end
    check("mid_queued", 32'(fifo_count), 32'd2);
    check("mid_bit3", 32'(tx), 32'(frame_bit(8'h55, 4)));
    rst = 1'b1;
    step();
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(tx_busy), 32'd0);
    check("mid_rst_count", 32'(fifo_count), 32'd0);
    step();
    rst = 1'b0;
    exp_q.delete();
    bad = 0;
    repeat (2 * BD) begin
      step();
      if (tx !== 1'b1) bad++;
    end
    check("mid_flushed", 32'(bad), 32'd0);
    push(8'hA5, e0);
    wait_idle(2 * FRAME);
    compare_rx();

    // Random bytes with short random gaps between pushes.
    for (int k = 0; k < 4; k++) begin
      r = 8'($urandom);
      push(r, en);
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle(6 * FRAME);
    for (int k = 1; k < fs_q.size(); k++)
      check($sformatf("rand_gap%0d", k), 32'(fs_q[k] - fs_q[0]), 32'(k * FRAME));
    compare_rx();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
